// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and one-cycle access sequencer for the 24 x 12 data memory.
// Each grant becomes one ACCESS cycle and a registered done pulse on the owning port.
module dmem_arbiter #(
  parameter int DEPTH = 24,
  parameter int AW    = 12,
  parameter int DW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p0_gnt,
  output logic          p1_gnt,
  output logic          p0_done,
  output logic          p1_done,
  output logic          rsp_err,
  output logic [DW-1:0] rsp_rdata,
  output logic          mem_write,
  output logic          mem_read,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state;
  logic          last_served;
  logic          id_p1;
  logic          we_p1;
  logic          any_req;
  logic          win_p1;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Unsigned compare over all AW bits: no wrap, so 12'hFFF is out of range too.
  function automatic logic in_range(input logic [AW-1:0] a);
    return a < AW'(DEPTH);
  endfunction

  function automatic logic [DW-1:0] rsp_data(input logic we, input logic ok,
                                             input logic [DW-1:0] rdata);
    return (!we && ok) ? rdata : '0;
  endfunction

  // Stage p0: arbitration; port 1 wins alone, or on a tie when port 0 was served last.
  always_comb begin
    any_req   = p0_req | p1_req;
    win_p1    = p1_req & (~p0_req | ~last_served);
    sel_we    = win_p1 ? p1_we    : p0_we;
    sel_addr  = win_p1 ? p1_addr  : p0_addr;
    sel_wdata = win_p1 ? p1_wdata : p0_wdata;
    p0_gnt    = 1'b0;
    p1_gnt    = 1'b0;
    if (state == IDLE && !reset) begin
      p0_gnt = any_req & ~win_p1;
      p1_gnt = win_p1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_served <= 1'b1;
      id_p1       <= 1'b0;
      we_p1       <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      p0_done     <= 1'b0;
      p1_done     <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      p0_done <= 1'b0;
      p1_done <= 1'b0;
      case (state)
        // Stage p1: command captured; strobes only for in-range addresses.
        IDLE: begin
          if (any_req) begin
            id_p1       <= win_p1;
            we_p1       <= sel_we;
            mem_addr    <= sel_addr;
            mem_wdata   <= sel_wdata;
            last_served <= win_p1;
            mem_write   <= sel_we & in_range(sel_addr);
            mem_read    <= ~sel_we & in_range(sel_addr);
            state       <= ACCESS;
          end
        end
        // Stage p2: response registered; rsp_err/rsp_rdata hold until the next done.
        ACCESS: begin
          mem_write <= 1'b0;
          mem_read  <= 1'b0;
          p0_done   <= ~id_p1;
          p1_done   <= id_p1;
          rsp_err   <= ~in_range(mem_addr);
          rsp_rdata <= rsp_data(we_p1, in_range(mem_addr), mem_rdata);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed corner sequences, a transaction table and a
// randomized run against a transaction-level reference model with a behavioural memory.
module tb_dmem_arbiter;
  localparam int DEPTH = 24;
  localparam int AW    = 12;
  localparam int DW    = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_gnt, p1_gnt, p0_done, p1_done, rsp_err;
  logic [DW-1:0] rsp_rdata, mem_wdata, mem_rdata;
  logic          mem_write, mem_read;
  logic [AW-1:0] mem_addr;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_done(p0_done), .p1_done(p1_done),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural data memory: synchronous write, combinational read.
  logic [DW-1:0] bmem [0:31];
  logic          mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) bmem[i] <= '0;
    end else if (mem_write && mem_addr < DEPTH) begin
      bmem[mem_addr[4:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = (mem_read && mem_addr < DEPTH) ? bmem[mem_addr[4:0]] : '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_p0_gnt"}, p0_gnt, 0);
    chk({tag, "_p1_gnt"}, p1_gnt, 0);
    chk({tag, "_p0_done"}, p0_done, 0);
    chk({tag, "_p1_done"}, p1_done, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_mem_write"}, mem_write, 0);
    chk({tag, "_mem_read"}, mem_read, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (p == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  // One isolated transaction, entered and left on a falling edge.
  task automatic do_txn(input int p, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic exp_err,
                        input logic [DW-1:0] exp_rdata);
    logic ok;
    ok = (addr < DEPTH);
    drive(p, 1'b1, we, addr, wdata);
    #1;
    chk("txn_gnt_own", (p == 0) ? p0_gnt : p1_gnt, 1);
    chk("txn_gnt_other", (p == 0) ? p1_gnt : p0_gnt, 0);
    @(negedge clk);
    drive(p, 1'b0, 1'b0, '0, '0);
    #1;
    chk("txn_mem_write", mem_write, we & ok);
    chk("txn_mem_read", mem_read, ~we & ok);
    chk("txn_mem_addr", mem_addr, addr);
    @(negedge clk);
    #1;
    chk("txn_done_own", (p == 0) ? p0_done : p1_done, 1);
    chk("txn_done_other", (p == 0) ? p1_done : p0_done, 0);
    chk("txn_err", rsp_err, exp_err);
    chk("txn_rdata", rsp_rdata, exp_rdata);
    @(negedge clk);
  endtask

  // Tie between two reads: port 0 must win first, then port 1.
  task automatic tie_pair(input string tag, input logic [AW-1:0] a0,
                          input logic [DW-1:0] exp0);
    drive(0, 1'b1, 1'b0, a0, '0);
    drive(1, 1'b1, 1'b0, 12'd9, '0);
    #1;
    chk({tag, "_tie_p0_gnt"}, p0_gnt, 1);
    chk({tag, "_tie_p1_gnt"}, p1_gnt, 0);
    @(negedge clk);
    p0_req = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, "_tie_p0_done"}, p0_done, 1);
    chk({tag, "_tie_p0_rdata"}, rsp_rdata, exp0);
    chk({tag, "_tie_p1_gnt2"}, p1_gnt, 1);
    @(negedge clk);
    p1_req = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, "_tie_p1_done"}, p1_done, 1);
    @(negedge clk);
  endtask

  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  typedef struct {
    int            port;
    logic          err;
    logic [DW-1:0] rdata;
    int            due;
  } rsp_t;

  vec_t          vecs [9];
  rsp_t          q[$];
  rsp_t          r;
  logic          pend [2];
  logic          cwe [2];
  logic [AW-1:0] caddr [2];
  logic [DW-1:0] cwd [2];
  logic [DW-1:0] shadow [0:DEPTH-1];

  initial begin
    int   next_idle, last, w;
    logic prev_strobe, ed0, ed1;

    vecs[0] = '{0, 1'b1, 12'd5,     12'hABC, 1'b0, 12'h000};
    vecs[1] = '{0, 1'b0, 12'd5,     12'h000, 1'b0, 12'hABC};
    vecs[2] = '{1, 1'b1, 12'd24,    12'h555, 1'b1, 12'h000};
    vecs[3] = '{1, 1'b0, 12'hFFF,   12'h000, 1'b1, 12'h000};
    vecs[4] = '{1, 1'b1, 12'd23,    12'h5A5, 1'b0, 12'h000};
    vecs[5] = '{1, 1'b0, 12'd23,    12'h000, 1'b0, 12'h5A5};
    vecs[6] = '{0, 1'b1, 12'd7,     12'h123, 1'b0, 12'h000};
    vecs[7] = '{1, 1'b0, 12'd7,     12'h000, 1'b0, 12'h123};
    vecs[8] = '{0, 1'b0, 12'd0,     12'h000, 1'b0, 12'h000};

    reset = 1'b1;
    mem_clr = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    mem_clr = 1'b0;

    // Continuous contention: grants alternate p0, p1, ... every other cycle.
    drive(0, 1'b1, 1'b0, 12'd1, '0);
    drive(1, 1'b1, 1'b0, 12'd2, '0);
    for (int k = 0; k <= 8; k++) begin
      if (k == 8) begin
        p0_req = 1'b0;
        p1_req = 1'b0;
      end
      #1;
      chk("cont_p0_gnt", p0_gnt, (k < 8 && k % 2 == 0 && (k / 2) % 2 == 0));
      chk("cont_p1_gnt", p1_gnt, (k < 8 && k % 2 == 0 && (k / 2) % 2 == 1));
      chk("cont_p0_done", p0_done, (k >= 2 && k % 2 == 0 && ((k - 2) / 2) % 2 == 0));
      chk("cont_p1_done", p1_done, (k >= 2 && k % 2 == 0 && ((k - 2) / 2) % 2 == 1));
      @(negedge clk);
    end

    // Reset during ACCESS of a p1 write: outputs clear at once, no done, no write.
    drive(1, 1'b1, 1'b1, 12'd3, 12'h777);
    #1;
    chk("midrst_p1_gnt", p1_gnt, 1);
    @(negedge clk);
    p1_req = 1'b0;
    #1;
    chk("midrst_mem_write", mem_write, 1);
    reset = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_no_done0", p0_done, 0);
    chk("midrst_no_done1", p1_done, 0);
    @(negedge clk);
    tie_pair("after_rst1", 12'd3, 12'h000);

    // Reset while p0 owns ACCESS must restore port 0 priority on the next tie.
    drive(0, 1'b1, 1'b0, 12'd4, '0);
    @(negedge clk);
    p0_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tie_pair("after_rst2", 12'd4, 12'h000);

    // Lone p1 with req held: a grant every second cycle, never on p0.
    drive(1, 1'b1, 1'b0, 12'd4, '0);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("solo_p1_gnt", p1_gnt, (k % 2 == 0));
      chk("solo_p0_gnt", p0_gnt, 0);
      @(negedge clk);
    end
    p1_req = 1'b0;
    repeat (2) @(negedge clk);
    tie_pair("solo_last", 12'd4, 12'h000);

    for (int i = 0; i < 9; i++)
      do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_err, vecs[i].exp_rdata);

    // Randomized traffic against the transaction-level model.
    reset = 1'b1;
    mem_clr = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mem_clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    next_idle = 0;
    last = 1;
    prev_strobe = 1'b0;
    for (int t = 0; t < 600; t++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && t < 590 && $urandom_range(0, 2) != 0) begin
          pend[p]  = 1'b1;
          cwe[p]   = 1'($urandom_range(0, 1));
          caddr[p] = ($urandom_range(0, 4) == 0) ? 12'($urandom_range(24, 4095))
                                                 : 12'($urandom_range(0, 7));
          cwd[p]   = 12'($urandom);
        end
        drive(p, pend[p], cwe[p], caddr[p], cwd[p]);
      end
      #1;
      w = -1;
      if (t >= next_idle && (pend[0] || pend[1]))
        w = (pend[0] && pend[1]) ? ((last == 1) ? 0 : 1) : (pend[1] ? 1 : 0);
      chk("rnd_p0_gnt", p0_gnt, (w == 0));
      chk("rnd_p1_gnt", p1_gnt, (w == 1));
      ed0 = 1'b0;
      ed1 = 1'b0;
      if (q.size() > 0 && q[0].due == t) begin
        r = q.pop_front();
        ed0 = (r.port == 0);
        ed1 = (r.port == 1);
        chk("rnd_err", rsp_err, r.err);
        chk("rnd_rdata", rsp_rdata, r.rdata);
      end
      chk("rnd_p0_done", p0_done, ed0);
      chk("rnd_p1_done", p1_done, ed1);
      chk("rnd_strobe_gap", prev_strobe & (mem_write | mem_read), 0);
      prev_strobe = mem_write | mem_read;
      if (w >= 0) begin
        r.port  = w;
        r.err   = (caddr[w] >= DEPTH);
        r.rdata = (!cwe[w] && !r.err) ? shadow[caddr[w]] : '0;
        r.due   = t + 2;
        if (cwe[w] && !r.err) shadow[caddr[w]] = cwd[w];
        q.push_back(r);
        last = w;
        next_idle = t + 2;
        pend[w] = 1'b0;
      end
      @(negedge clk);
    end
    chk("rnd_all_done", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
